// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster position counter and TMDS period sequencer.
// Every output is registered and describes the pixel at (cx, cy), so the
// next-pixel position and its period are computed together and captured on one edge.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int HS_START = 656,
    parameter int HS_END   = 752,
    parameter int VS_START = 490,
    parameter int VS_END   = 492,
    parameter int DI_START = 648
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        packet_valid,
    output logic [10:0] cx,
    output logic [9:0]  cy,
    output logic [2:0]  mode,
    output logic [3:0]  ctl,
    output logic [1:0]  sync_ctl,
    output logic        packet_start,
    output logic [4:0]  packet_idx
);

    localparam logic [2:0] ST_CTRL        = 3'd0;
    localparam logic [2:0] ST_VID_PRE     = 3'd1;
    localparam logic [2:0] ST_VID_GB      = 3'd2;
    localparam logic [2:0] ST_VIDEO       = 3'd3;
    localparam logic [2:0] ST_DI_PRE      = 3'd4;
    localparam logic [2:0] ST_DI_GB_LEAD  = 3'd5;
    localparam logic [2:0] ST_DI_DATA     = 3'd6;
    localparam logic [2:0] ST_DI_GB_TRAIL = 3'd7;

    localparam logic [10:0] X_ACTIVE   = 11'(H_ACTIVE);
    localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_VID_PRE  = 11'(H_TOTAL - 10);
    localparam logic [10:0] X_VID_GB   = 11'(H_TOTAL - 2);
    localparam logic [10:0] X_DI       = 11'(DI_START);
    localparam logic [10:0] X_DI_GB    = 11'(DI_START + 8);
    localparam logic [10:0] X_DI_DATA  = 11'(DI_START + 10);
    localparam logic [10:0] X_DI_TRAIL = 11'(DI_START + 42);
    localparam logic [10:0] X_DI_END   = 11'(DI_START + 44);
    localparam logic [10:0] X_HS0      = 11'(HS_START);
    localparam logic [10:0] X_HS1      = 11'(HS_END);
    localparam logic [9:0]  Y_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_VS0      = 10'(VS_START);
    localparam logic [9:0]  Y_VS1      = 10'(VS_END);

    // Timing sanity: the island must fit between active video and the video preamble.
    generate
        if (DI_START < H_ACTIVE + 4) begin : g_err_di_early
            $error("DI_START must be at least H_ACTIVE+4");
        end
        if (DI_START + 48 > H_TOTAL - 10) begin : g_err_di_late
            $error("DI_START+48 must not exceed H_TOTAL-10");
        end
        if (HS_END > H_TOTAL) begin : g_err_hs
            $error("HS_END must not exceed H_TOTAL");
        end
        if (VS_END > V_TOTAL) begin : g_err_vs
            $error("VS_END must not exceed V_TOTAL");
        end
        if (V_ACTIVE >= V_TOTAL) begin : g_err_vact
            $error("V_ACTIVE must be below V_TOTAL");
        end
    endgenerate

    function automatic logic [1:0] sync_of(input logic [10:0] x, input logic [9:0] y);
        return {(y >= Y_VS0) && (y < Y_VS1), (x >= X_HS0) && (x < X_HS1)};
    endfunction

    logic [10:0] cx_q, cx_d;
    logic [9:0]  cy_q, cy_d;
    logic [2:0]  state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [3:0]  ctl_q, ctl_d;
    logic [1:0]  sync_ctl_q, sync_ctl_d;
    logic        packet_start_q, packet_start_d;
    logic [4:0]  packet_idx_q, packet_idx_d;
    logic [9:0]  cy_after;
    logic        island_live;
    logic        island_on;

    // Next pixel position and the period that pixel belongs to.
    always_comb begin
        cx_d = (cx_q == X_LAST) ? 11'd0 : cx_q + 11'd1;
        cy_d = cy_q;
        if (cx_q == X_LAST) begin
            cy_d = (cy_q == Y_LAST) ? 10'd0 : cy_q + 10'd1;
        end
        cy_after = (cy_d == Y_LAST) ? 10'd0 : cy_d + 10'd1;

        // An island is only committed at the edge that lands on DI_START; after
        // that it runs to completion regardless of packet_valid.
        island_live = (state_q == ST_DI_PRE) || (state_q == ST_DI_GB_LEAD) ||
                      (state_q == ST_DI_DATA) || (state_q == ST_DI_GB_TRAIL);
        island_on = ((cx_d == X_DI) && packet_valid) ||
                    (island_live && (cx_d > X_DI) && (cx_d < X_DI_END));

        state_d = ST_CTRL;
        if ((cx_d < X_ACTIVE) && (cy_d < Y_ACTIVE)) begin
            state_d = ST_VIDEO;
        end else if (island_on) begin
            if (cx_d < X_DI_GB) begin
                state_d = ST_DI_PRE;
            end else if (cx_d < X_DI_DATA) begin
                state_d = ST_DI_GB_LEAD;
            end else if (cx_d < X_DI_TRAIL) begin
                state_d = ST_DI_DATA;
            end else begin
                state_d = ST_DI_GB_TRAIL;
            end
        end else if ((cy_after < Y_ACTIVE) && (cx_d >= X_VID_PRE)) begin
            state_d = (cx_d >= X_VID_GB) ? ST_VID_GB : ST_VID_PRE;
        end

        case (state_d)
            ST_VIDEO:                      mode_d = 3'd1;
            ST_VID_GB:                     mode_d = 3'd2;
            ST_DI_DATA:                    mode_d = 3'd3;
            ST_DI_GB_LEAD, ST_DI_GB_TRAIL: mode_d = 3'd4;
            default:                       mode_d = 3'd0;
        endcase

        case (state_d)
            ST_VID_PRE: ctl_d = 4'b0001;
            ST_DI_PRE:  ctl_d = 4'b0101;
            default:    ctl_d = 4'b0000;
        endcase

        packet_idx_d   = (state_d == ST_DI_DATA) ? 5'(cx_d - X_DI_DATA) : 5'd0;
        packet_start_d = (state_d == ST_DI_DATA) && (cx_d == X_DI_DATA);
        sync_ctl_d     = sync_of(cx_d, cy_d);
    end

    // Output and state registers; reset parks on the last blanking line.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cx_q           <= 11'd0;
            cy_q           <= Y_LAST;
            state_q        <= ST_CTRL;
            mode_q         <= 3'd0;
            ctl_q          <= 4'd0;
            sync_ctl_q     <= sync_of(11'd0, Y_LAST);
            packet_start_q <= 1'b0;
            packet_idx_q   <= 5'd0;
        end else begin
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            state_q        <= state_d;
            mode_q         <= mode_d;
            ctl_q          <= ctl_d;
            sync_ctl_q     <= sync_ctl_d;
            packet_start_q <= packet_start_d;
            packet_idx_q   <= packet_idx_d;
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign mode         = mode_q;
    assign ctl          = ctl_q;
    assign sync_ctl     = sync_ctl_q;
    assign packet_start = packet_start_q;
    assign packet_idx   = packet_idx_q;

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, active pixels per line; H_TOTAL 800, pixels per line; V_ACTIVE 480, active lines; V_TOTAL 525, lines per frame; HS_START 656 and HS_END 752, hsync span in pixels; VS_START 490 and VS_END 492, vsync span in lines; DI_START 648, pixel at which a data-island preamble starts.
REQ-002 SHALL have ports: clk_pixel in 1, pixel clock; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: packet_valid in 1, a 32-pixel packet is pending; cx out 11, pixel column; cy out 10, line number; mode out 3, TMDS period code (0 control, 1 video, 2 video guard, 3 island, 4 island guard); ctl out 4, CTL3..CTL0; sync_ctl out 2, {vsync,hsync}; packet_start out 1, first island data pixel; packet_idx out 5, island data pixel index.
REQ-004 SHALL use one clock, clk_pixel, with reset_n asynchronous and active-low.
REQ-005 SHALL register every output; all outputs refer to the same pixel (cx,cy), so all have zero relative skew.

Function
REQ-006 SHALL increment cx every cycle, wrapping from H_TOTAL-1 to 0; at that wrap, cy SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-007 SHALL define active(x,y) as x<H_ACTIVE and y<V_ACTIVE.
REQ-008 SHALL implement states CTRL, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_GB_LEAD, DI_DATA, DI_GB_TRAIL, with one state per pixel.
REQ-009 SHALL enter VIDEO for every pixel where active(cx,cy) holds.
REQ-010 SHALL enter VID_PRE for cx in [H_TOTAL-10, H_TOTAL-3] (8 pixels) and VID_GB for cx in [H_TOTAL-2, H_TOTAL-1] (2 pixels), but only when the next line, (cy+1) mod V_TOTAL, is below V_ACTIVE.
REQ-011 SHALL commit an island when packet_valid=1 is sampled on the edge at which cx becomes DI_START; packet_valid SHALL be ignored at all other times, including deassertion mid-island.
REQ-012 SHALL sequence a committed island, on any line including vertical blanking, as DI_PRE for 8 pixels, DI_GB_LEAD for 2, DI_DATA for 32, DI_GB_TRAIL for 2 (44 pixels total), then CTRL.
REQ-013 SHALL allow at most one island per line.
REQ-014 SHALL use CTRL for every other pixel.
REQ-015 SHALL map mode: CTRL, VID_PRE and DI_PRE to 0; VIDEO to 1; VID_GB to 2; DI_DATA to 3; DI_GB_LEAD and DI_GB_TRAIL to 4.
REQ-016 SHALL drive ctl = 4'b0001 in VID_PRE, 4'b0101 in DI_PRE, and 4'b0000 otherwise.
REQ-017 SHALL drive sync_ctl[0]=1 when cx is in [HS_START, HS_END), and sync_ctl[1]=1 when cy is in [VS_START, VS_END).
REQ-018 SHALL drive sync_ctl in all states, because it feeds channel-0 control and island guard coding.
REQ-019 SHALL count packet_idx 0..31 during DI_DATA and hold it at 0 otherwise.
REQ-020 SHALL pulse packet_start high for exactly one cycle, at packet_idx=0.
REQ-021 SHALL check parameters at elaboration, failing on any violation: DI_START>=H_ACTIVE+4; DI_START+48<=H_TOTAL-10; HS_END<=H_TOTAL; VS_END<=V_TOTAL; V_ACTIVE<V_TOTAL.
REQ-022 SHALL give VIDEO priority over any island state if a parameter violation is ever simulated unchecked.

Reset
REQ-023 SHALL, while reset_n=0, force: cx=0; cy=V_TOTAL-1; state CTRL; mode=0; ctl=0; packet_start=0; packet_idx=0; sync_ctl equal to the value computed for (0, V_TOTAL-1).
REQ-024 SHALL start in the last blanking line after reset, so the first active line gets a full preamble and guard band.
REQ-025 SHALL respond to reset_n asserted mid-island or mid-preamble immediately, asynchronously; any committed island SHALL be discarded and SHALL NOT resume after release.
REQ-026 SHALL begin counting on the first clk_pixel edge after reset_n deasserts.

Verification
REQ-027 Reset release with packet_valid=0 -> cx=790..797: mode=0, ctl=0001; cx=798..799: mode=2; at (0,0): mode=1; cy=V_TOTAL-1 shows no VIDEO.
REQ-028 packet_valid=1 held on line 5 -> cx 648..655: ctl=0101, mode=0; cx 656..657: mode=4; cx 658..689: mode=3, packet_idx 0..31, packet_start only at 658; cx 690..691: mode=4; cx 692: mode=0.
REQ-029 packet_valid pulsed high only at the cycle cx=647->648 -> island occurs; pulse at cx=649 only -> no island on that line.
REQ-030 Line 479 and line 524 -> line 479 ends with mode 0 and no VID_PRE; line 524 ends with VID_PRE then VID_GB; vsync high exactly on lines 490..491; hsync high exactly on cx 656..751.
REQ-031 reset_n asserted at cx=670 during DI_DATA -> outputs take reset values without a clock edge; after release, no mode=3 until the next commit.
REQ-032 packet_valid=1 permanently for 2 frames -> exactly one island per line on all 525 lines; mode never 3 while cx<H_ACTIVE.
